// File: rtl/parking_gate_allocator.sv
// Entry/exit controller for a small car park: owns the free-space bitmap fed to
// park_space_number, admits one car per IDLE visit and holds the entry gate open.
module parking_gate_allocator #(
   parameter int unsigned GATE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       car_enter,
   input  logic       car_exit,
   input  logic [2:0] exit_space,
   input  logic [2:0] park_number,
   output logic [7:0] parking_capacity,
   output logic       encoder_enable,
   output logic [2:0] assigned_space,
   output logic       assign_valid,
   output logic       gate_open,
   output logic       busy,
   output logic       full,
   output logic [3:0] free_count,
   output logic       entry_rejected,
   output logic       exit_error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      GATE   = 2'd2
   } state_t;

   localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES);

   state_t     state;
   state_t     state_next;
   logic [7:0] gate_cnt;

   logic       allocate;
   logic [7:0] alloc_mask;
   logic       exit_ok;
   logic       exit_bad;
   logic [7:0] exit_mask;
   logic [7:0] capacity_next;
   logic [3:0] count_next;

   // Bitmap update: an allocation and an exit may land on the same edge; an exit
   // of the space being allocated sees a free bit and is therefore an error.
   always_comb begin
      allocate      = (state == LOOKUP);
      alloc_mask    = allocate ? (8'b1 << park_number) : 8'h00;
      exit_mask     = 8'b1 << exit_space;
      exit_ok       = car_exit && !parking_capacity[exit_space];
      exit_bad      = car_exit &&  parking_capacity[exit_space];
      capacity_next = (parking_capacity & ~alloc_mask) | (exit_ok ? exit_mask : 8'h00);
      count_next    = free_count;
      case ({exit_ok, allocate})
         2'b10:   count_next = free_count + 4'd1;
         2'b01:   count_next = free_count - 4'd1;
         default: count_next = free_count;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (car_enter && !full) begin
               state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            state_next = GATE;
         end
         GATE: begin
            if (gate_cnt <= 8'd1) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Gate timer loads while the space is being assigned, then counts the open cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt <= 8'd0;
      end else if (state == LOOKUP) begin
         gate_cnt <= GATE_LOAD;
      end else if (state == GATE && gate_cnt != 8'd0) begin
         gate_cnt <= gate_cnt - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parking_capacity <= 8'hFF;
         free_count       <= 4'd8;
         full             <= 1'b0;
      end else begin
         parking_capacity <= capacity_next;
         free_count       <= count_next;
         full             <= (capacity_next == 8'h00);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         assigned_space <= 3'b000;
         assign_valid   <= 1'b0;
         entry_rejected <= 1'b0;
         exit_error     <= 1'b0;
      end else begin
         if (allocate) begin
            assigned_space <= park_number;
         end
         assign_valid   <= allocate;
         entry_rejected <= (state == IDLE) && car_enter && full;
         exit_error     <= exit_bad;
      end
   end

   // Decoded from state so the gate drops the instant reset asserts.
   always_comb begin
      encoder_enable = (state == LOOKUP);
      gate_open      = (state == GATE);
      busy           = (state != IDLE);
   end

endmodule

// File: tb/tb_parking_gate_allocator.sv
// Bench for parking_gate_allocator: directed scenarios then random traffic, all
// checked each cycle against a timestamp-based model of admissions and the lot.
module tb_parking_gate_allocator;

   localparam int G = 4;

   logic       clk;
   logic       rst_n;
   logic       car_enter;
   logic       car_exit;
   logic [2:0] exit_space;
   logic [2:0] park_number;
   logic [7:0] parking_capacity;
   logic       encoder_enable;
   logic [2:0] assigned_space;
   logic       assign_valid;
   logic       gate_open;
   logic       busy;
   logic       full;
   logic [3:0] free_count;
   logic       entry_rejected;
   logic       exit_error;

   int checks = 0;
   int errors = 0;

   // Model: lot contents plus the cycle index at which the current admission looks up.
   logic [7:0] m_cap;
   logic [2:0] m_assigned;
   logic       m_av;
   logic       m_rej;
   logic       m_err;
   int         cyc;
   int         lookup_at;

   parking_gate_allocator #(.GATE_CYCLES(G)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .car_enter(car_enter),
      .car_exit(car_exit),
      .exit_space(exit_space),
      .park_number(park_number),
      .parking_capacity(parking_capacity),
      .encoder_enable(encoder_enable),
      .assigned_space(assigned_space),
      .assign_valid(assign_valid),
      .gate_open(gate_open),
      .busy(busy),
      .full(full),
      .free_count(free_count),
      .entry_rejected(entry_rejected),
      .exit_error(exit_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] lowestFree(input logic [7:0] cap);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (cap[i]) r = 3'(i);
      end
      return r;
   endfunction

   function automatic int popCount(input logic [7:0] cap);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(cap[i]);
      return n;
   endfunction

   // Stand-in for park_space_number.
   assign park_number = encoder_enable ? lowestFree(parking_capacity) : 3'bzzz;

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic modelReset();
      m_cap      = 8'hFF;
      m_assigned = 3'd0;
      m_av       = 1'b0;
      m_rej      = 1'b0;
      m_err      = 1'b0;
      lookup_at  = -1;
   endtask

   task automatic checkOutput();
      logic e_look;
      logic e_gate;
      e_look = (lookup_at == cyc);
      e_gate = (lookup_at >= 0) && (cyc > lookup_at) && (cyc <= lookup_at + G);
      cmp("capacity",   parking_capacity,       m_cap);
      cmp("free_count", 8'(free_count),         8'(popCount(m_cap)));
      cmp("full",       8'(full),               8'(m_cap == 8'h00));
      cmp("enc_enable", 8'(encoder_enable),     8'(e_look));
      cmp("gate_open",  8'(gate_open),          8'(e_gate));
      cmp("busy",       8'(busy),               8'(e_look || e_gate));
      cmp("assigned",   8'(assigned_space),     8'(m_assigned));
      cmp("assign_vld", 8'(assign_valid),       8'(m_av));
      cmp("rejected",   8'(entry_rejected),     8'(m_rej));
      cmp("exit_error", 8'(exit_error),         8'(m_err));
   endtask

   // Advance the model across one clock edge with the given inputs.
   task automatic stepModel(input logic enter, input logic ex, input logic [2:0] sp);
      logic       in_look;
      logic       in_gate;
      logic [7:0] nc;
      logic [2:0] idx;
      in_look = (lookup_at == cyc);
      in_gate = (lookup_at >= 0) && (cyc > lookup_at) && (cyc <= lookup_at + G);
      idx     = lowestFree(m_cap);
      nc      = m_cap;
      m_av    = 1'b0;
      m_rej   = 1'b0;
      m_err   = 1'b0;
      if (in_look) begin
         nc[idx]    = 1'b0;
         m_assigned = idx;
         m_av       = 1'b1;
      end
      if (ex) begin
         if (m_cap[sp]) m_err = 1'b1;
         else nc[sp] = 1'b1;
      end
      if (!in_look && !in_gate && enter) begin
         if (m_cap == 8'h00) m_rej = 1'b1;
         else lookup_at = cyc + 1;
      end
      m_cap = nc;
      cyc++;
   endtask

   task automatic applyStimulus(input logic enter, input logic ex, input logic [2:0] sp);
      car_enter  = enter;
      car_exit   = ex;
      exit_space = sp;
      stepModel(enter, ex, sp);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #3;
      modelReset();
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic admitOne();
      applyStimulus(1'b1, 1'b0, 3'd0);
      for (int i = 0; i < G + 1; i++) applyStimulus(1'b0, 1'b0, 3'd0);
   endtask

   initial begin
      cyc        = 0;
      rst_n      = 1'b0;
      car_enter  = 1'b0;
      car_exit   = 1'b0;
      exit_space = 3'd0;
      modelReset();
      @(negedge clk);
      doReset();

      $display("[TB] single admission");
      admitOne();
      cmp("t1_capacity", parking_capacity, 8'hFE);
      cmp("t1_count",    8'(free_count),   8'd7);
      cmp("t1_assigned", 8'(assigned_space), 8'd0);

      $display("[TB] fill the lot then reject");
      for (int k = 0; k < 7; k++) admitOne();
      cmp("t2_capacity", parking_capacity, 8'h00);
      cmp("t2_full",     8'(full),         8'd1);
      applyStimulus(1'b1, 1'b0, 3'd0);
      cmp("t2_rejected", 8'(entry_rejected), 8'd1);
      applyStimulus(1'b0, 1'b0, 3'd0);
      cmp("t2_gate",     8'(gate_open),    8'd0);

      $display("[TB] exit from full lot");
      applyStimulus(1'b0, 1'b1, 3'd5);
      cmp("t3_capacity", parking_capacity, 8'h20);
      cmp("t3_count",    8'(free_count),   8'd1);
      admitOne();
      cmp("t3_assigned", 8'(assigned_space), 8'd5);

      $display("[TB] exit of a free space");
      doReset();
      applyStimulus(1'b0, 1'b1, 3'd3);
      cmp("t4_exit_error", 8'(exit_error),  8'd1);
      cmp("t4_capacity",   parking_capacity, 8'hFF);

      $display("[TB] exit coinciding with allocation");
      for (int k = 0; k < 3; k++) admitOne();
      applyStimulus(1'b1, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 3'd1);
      cmp("t5_capacity", parking_capacity, 8'hF2);
      cmp("t5_count",    8'(free_count),   8'd5);
      for (int i = 0; i < G; i++) applyStimulus(1'b0, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 3'd4);
      applyStimulus(1'b0, 1'b0, 3'd0);

      $display("[TB] reset during gate with entry held");
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 3'd0);
      #2 rst_n = 1'b0;
      #1;
      cmp("t6_gate_async", 8'(gate_open), 8'd0);
      cmp("t6_capacity",   parking_capacity, 8'hFF);
      modelReset();
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 3'd0);
      applyStimulus(1'b1, 1'b0, 3'd0);
      cmp("t6_assigned", 8'(assigned_space), 8'd0);
      cmp("t6_valid",    8'(assign_valid),   8'd1);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                       3'($urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
